// File: rtl/fft_pkg.sv
// Shared types and defaults for the in-place radix-2 DIF FFT sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package fft_pkg;

  // Sample width used by the butterfly datapath (sign-magnitude fixed point).
  localparam int DATA_W = 16;

  // Default log2 of the FFT size.
  localparam int FFT_LOG2N = 4;

  // Sequencer control states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    SYNC = 2'd2,
    DONE = 2'd3
  } seq_state_t;

endpackage

// File: rtl/fft_addr_gen.sv
// Maps (stage, butterfly count) to the DIF address pair and twiddle index.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides when the result is used.
module fft_addr_gen
  import fft_pkg::*;
#(
  parameter int LOG2N   = FFT_LOG2N,
  parameter int STAGE_W = 3
) (
  input  logic [STAGE_W-1:0] stage,
  input  logic [LOG2N-2:0]   bf_cnt,
  output logic [LOG2N-1:0]   addr_a,
  output logic [LOG2N-1:0]   addr_b,
  output logic [LOG2N-2:0]   k
);

  // The span is a power of two, so bf_cnt splits into a group part (high bits)
  // and a position part (low bits) with a mask; no divider is needed.
  logic [LOG2N-2:0] pos_mask;
  logic [LOG2N-2:0] pos;
  logic [LOG2N-2:0] grp_bits;
  logic [LOG2N-1:0] span;

  assign pos_mask = {(LOG2N-1){1'b1}} >> stage;
  assign pos      = bf_cnt & pos_mask;
  assign grp_bits = bf_cnt & ~pos_mask;
  assign span     = {1'b0, pos_mask} + 1'b1;

  // Group base is grp*2*span: shifting the group bits left by one inserts the
  // lower-wing bit, which is always zero for the upper-wing address.
  assign addr_a = {grp_bits, 1'b0} | {1'b0, pos};
  assign addr_b = addr_a | span;

  // Twiddle exponent pos<<stage; the truncation to LOG2N-1 bits is the mod N/2.
  assign k = pos << stage;

endmodule

// File: rtl/fft_stage_sequencer.sv
// Runs LOG2N stages of N/2 in-place DIF butterflies over a sync RAM, writing each pair back one cycle after it is read.
// Latency: start -> done in LOG2N*(N/2+1)+1 cycles with hold low; reads to writes are exactly one cycle.
// Backpressure: hold stalls read issue in RUN only (an in-flight write still lands); optional per-stage scaling under FFT_SCALE_EN.
module fft_stage_sequencer
  import fft_pkg::*;
#(
  parameter int LOG2N   = FFT_LOG2N,
  parameter int STAGE_W = 3
) (
  input  logic               clk,
  input  logic               n_rst,
  input  logic               start,
  input  logic               hold,
`ifdef FFT_SCALE_EN
  input  logic [LOG2N-1:0]   scale_mask,
  output logic               bf_scale,
`endif
  output logic               busy,
  output logic               done,
  output logic [STAGE_W-1:0] stage,
  output logic               rd_en,
  output logic [LOG2N-1:0]   rd_addr_a,
  output logic [LOG2N-1:0]   rd_addr_b,
  output logic               wr_en,
  output logic [LOG2N-1:0]   wr_addr_a,
  output logic [LOG2N-1:0]   wr_addr_b,
  output logic [LOG2N-2:0]   tw_idx
);

  localparam logic [LOG2N-2:0]   BF_LAST    = '1;
  localparam logic [STAGE_W-1:0] STAGE_LAST = STAGE_W'(LOG2N - 1);

  seq_state_t       state;
  logic [LOG2N-2:0] bf_cnt;
  logic [LOG2N-1:0] gen_addr_a;
  logic [LOG2N-1:0] gen_addr_b;
  logic [LOG2N-2:0] gen_k;

  fft_addr_gen #(
    .LOG2N   (LOG2N),
    .STAGE_W (STAGE_W)
  ) u_addr_gen (
    .stage  (stage),
    .bf_cnt (bf_cnt),
    .addr_a (gen_addr_a),
    .addr_b (gen_addr_b),
    .k      (gen_k)
  );

  // Read issue is combinational so hold takes effect in the same cycle;
  // addresses are forced to zero whenever no read is issued.
  assign rd_en     = (state == RUN) && !hold;
  assign rd_addr_a = rd_en ? gen_addr_a : '0;
  assign rd_addr_b = rd_en ? gen_addr_b : '0;

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  // Control FSM with butterfly and stage counters. SYNC is a one-cycle bubble
  // so the first read of a stage never hits the pair being written that cycle.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state  <= IDLE;
      stage  <= '0;
      bf_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state  <= RUN;
            stage  <= '0;
            bf_cnt <= '0;
          end
        end
        RUN: begin
          if (rd_en) begin
            // Wraps to zero after the last pair, ready for the next stage.
            bf_cnt <= bf_cnt + 1'b1;
            if (bf_cnt == BF_LAST) begin
              state <= SYNC;
            end
          end
        end
        SYNC: begin
          if (stage == STAGE_LAST) begin
            state <= DONE;
          end else begin
            state <= RUN;
            stage <= stage + 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Write side: one-cycle delayed copy of the read request so the butterfly
  // outputs, produced from next-cycle RAM data, land on the same pair.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wr_en     <= 1'b0;
      wr_addr_a <= '0;
      wr_addr_b <= '0;
      tw_idx    <= '0;
    end else begin
      wr_en     <= rd_en;
      wr_addr_a <= rd_addr_a;
      wr_addr_b <= rd_addr_b;
      tw_idx    <= rd_en ? gen_k : '0;
    end
  end

`ifdef FFT_SCALE_EN
  logic [LOG2N-1:0] mask_q;

  // Capture the per-stage scale mask once per run so it cannot change mid-FFT.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      mask_q <= '0;
    end else if ((state == IDLE) && start) begin
      mask_q <= scale_mask;
    end
  end

  // Scale flag travels with the write it applies to.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      bf_scale <= 1'b0;
    end else begin
      bf_scale <= rd_en && |(mask_q & (LOG2N'(1) << stage));
    end
  end
`endif

endmodule
